// File: rtl/board_io_conditioner.sv
// Board input conditioner: synchronises and debounces raw keys, emits press/release pulses,
// and sequences a stretched active-low system reset from PLL lock and an optional reset key.
module board_io_conditioner #(
    parameter int NUM_KEYS       = 5,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_COUNT = 50000,
    parameter int RESET_KEY      = 2,
    parameter int RESET_STRETCH  = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pll_locked,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_KEYS-1:0] keys_out,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] key_released,
    output logic                sys_reset_n,
    output logic [1:0]          reset_state
);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_COUNT = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_t;

    localparam int DB_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam int ST_W = (RESET_STRETCH > 1) ? $clog2(RESET_STRETCH) : 1;
    localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(DEBOUNCE_COUNT - 1);
    localparam logic [ST_W-1:0]     ST_LAST  = ST_W'(RESET_STRETCH - 1);
    localparam logic [NUM_KEYS-1:0] KEY_IDLE = {NUM_KEYS{KEY_ACTIVE_LOW}};

    logic [NUM_KEYS-1:0]    key_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] pll_sr;
    logic [NUM_KEYS-1:0]    key_level;
    logic                   pll_sync;
    logic [DB_W-1:0]        db_cnt [NUM_KEYS];
    logic                   reset_key_active;
    logic                   ok;
    seq_state_t             state;
    logic [ST_W-1:0]        st_cnt;

    // Key synchronisers start at the idle raw level so reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) key_sync[i] <= KEY_IDLE;
            pll_sr <= '0;
        end else begin
            // NOTE: non-blocking assignments let the shift chain read last-cycle values in any order.
            key_sync[0] <= keys_in;
            for (int i = 1; i < SYNC_STAGES; i++) key_sync[i] <= key_sync[i-1];
            pll_sr <= {pll_sr[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign key_level = key_sync[SYNC_STAGES-1] ^ KEY_IDLE;
    assign pll_sync  = pll_sr[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the counter array is reset too, so a half-finished debounce cannot survive a reset.
            for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
            keys_out     <= '0;
            key_pressed  <= '0;
            key_released <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_pressed[i]  <= 1'b0;
                key_released[i] <= 1'b0;
                if (key_level[i] == keys_out[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]       <= '0;
                    keys_out[i]     <= key_level[i];
                    key_pressed[i]  <= key_level[i];
                    key_released[i] <= ~key_level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    if (RESET_KEY >= 0) begin : g_reset_key
        assign reset_key_active = keys_out[RESET_KEY];
    end else begin : g_no_reset_key
        assign reset_key_active = 1'b0;
    end

    assign ok = pll_sync & ~reset_key_active;

    // The stretch counter parks at its last value in RUN, so it never passes RESET_STRETCH-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_HOLD;
            st_cnt      <= '0;
            sys_reset_n <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    sys_reset_n <= 1'b0;
                    if (ok) begin
                        state  <= ST_COUNT;
                        st_cnt <= '0;
                    end
                end
                ST_COUNT: begin
                    if (!ok) begin
                        state  <= ST_HOLD;
                        st_cnt <= '0;
                    end else if (st_cnt == ST_LAST) begin
                        state       <= ST_RUN;
                        sys_reset_n <= 1'b1;
                    end else begin
                        st_cnt <= st_cnt + ST_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!ok) begin
                        state       <= ST_HOLD;
                        sys_reset_n <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_HOLD;
                    sys_reset_n <= 1'b0;
                end
            endcase
        end
    end

    assign reset_state = state;

endmodule

// File: tb/tb_board_io_conditioner.sv
// Testbench for board_io_conditioner: a literal vector table, directed corner sequences,
// and randomized stimulus checked against a sample-window reference model.
module tb_board_io_conditioner;

    localparam int NK      = 5;
    localparam int SYNC    = 2;
    localparam int DEB     = 4;
    localparam int STRETCH = 8;
    localparam int RK      = 2;
    localparam logic [NK-1:0] IDLE_RAW = 5'h1F;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pll_locked;
    logic [NK-1:0] keys_in;
    logic [NK-1:0] keys_out;
    logic [NK-1:0] key_pressed;
    logic [NK-1:0] key_released;
    logic          sys_reset_n;
    logic [1:0]    reset_state;

    int checks   = 0;
    int failures = 0;

    board_io_conditioner #(
        .NUM_KEYS      (NK),
        .KEY_ACTIVE_LOW(1'b1),
        .SYNC_STAGES   (SYNC),
        .DEBOUNCE_COUNT(DEB),
        .RESET_KEY     (RK),
        .RESET_STRETCH (STRETCH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .keys_in     (keys_in),
        .keys_out    (keys_out),
        .key_pressed (key_pressed),
        .key_released(key_released),
        .sys_reset_n (sys_reset_n),
        .reset_state (reset_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Reference model: samples reach the debouncer SYNC edges after capture; a key flips when
    // its last DEB samples since reset all disagree with its level; reset deasserts once ok
    // has been seen true on STRETCH+1 consecutive edges.
    logic [NK-1:0] m_rawq[$];
    bit            m_pllq[$];
    logic [NK-1:0] m_hist[$];
    logic [NK-1:0] m_keys, m_pressed, m_released;
    int            m_okrun;

    task automatic model_reset();
        m_rawq = {};
        m_pllq = {};
        m_hist = {};
        for (int i = 0; i < SYNC; i++) begin
            m_rawq.push_back(IDLE_RAW);
            m_pllq.push_back(1'b0);
        end
        m_keys     = '0;
        m_pressed  = '0;
        m_released = '0;
        m_okrun    = 0;
    endtask

    task automatic model_step();
        logic [NK-1:0] s;
        bit            p;
        bit            all_diff;
        s = ~m_rawq.pop_front();
        m_rawq.push_back(keys_in);
        p = m_pllq.pop_front();
        m_pllq.push_back(pll_locked);
        if (p && !m_keys[RK]) m_okrun++;
        else m_okrun = 0;
        m_hist.push_back(s);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        m_pressed  = '0;
        m_released = '0;
        if (m_hist.size() == DEB) begin
            for (int k = 0; k < NK; k++) begin
                all_diff = 1'b1;
                foreach (m_hist[j]) if (m_hist[j][k] == m_keys[k]) all_diff = 1'b0;
                if (all_diff) begin
                    m_keys[k]     = s[k];
                    m_pressed[k]  = s[k];
                    m_released[k] = ~s[k];
                end
            end
        end
    endtask

    function automatic logic [1:0] m_state();
        if (m_okrun == 0) return 2'd0;
        if (m_okrun <= STRETCH) return 2'd1;
        return 2'd2;
    endfunction

    task automatic compare_model();
        check("model keys_out", 32'(keys_out), 32'(m_keys));
        check("model key_pressed", 32'(key_pressed), 32'(m_pressed));
        check("model key_released", 32'(key_released), 32'(m_released));
        check("model sys_reset_n", 32'(sys_reset_n), 32'(m_okrun > STRETCH));
        check("model reset_state", 32'(reset_state), 32'(m_state()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    // Reset pulse placed wholly between a falling edge and the next rising edge.
    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("async sys_reset_n", 32'(sys_reset_n), 32'(0));
        check("async keys_out", 32'(keys_out), 32'(0));
        check("async reset_state", 32'(reset_state), 32'(0));
        compare_model();
        #1 reset_n = 1'b1;
    endtask

    typedef struct {
        logic [NK-1:0] keys;
        logic          pll;
        logic [NK-1:0] ko;
        logic [NK-1:0] kp;
        logic [NK-1:0] kr;
        logic          srn;
        logic [1:0]    st;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // Edge-by-edge expectations after reset release: key0 pressed before edge 1 and
        // released before edge 12, PLL locked throughout.
        vecs[0]  = '{5'h1E, 1'b1, 5'h00, 5'h00, 5'h00, 1'b0, 2'd0};
        vecs[1]  = '{5'h1E, 1'b1, 5'h00, 5'h00, 5'h00, 1'b0, 2'd0};
        vecs[2]  = '{5'h1E, 1'b1, 5'h00, 5'h00, 5'h00, 1'b0, 2'd1};
        vecs[3]  = '{5'h1E, 1'b1, 5'h00, 5'h00, 5'h00, 1'b0, 2'd1};
        vecs[4]  = '{5'h1E, 1'b1, 5'h00, 5'h00, 5'h00, 1'b0, 2'd1};
        vecs[5]  = '{5'h1E, 1'b1, 5'h01, 5'h01, 5'h00, 1'b0, 2'd1};
        vecs[6]  = '{5'h1E, 1'b1, 5'h01, 5'h00, 5'h00, 1'b0, 2'd1};
        vecs[7]  = '{5'h1E, 1'b1, 5'h01, 5'h00, 5'h00, 1'b0, 2'd1};
        vecs[8]  = '{5'h1E, 1'b1, 5'h01, 5'h00, 5'h00, 1'b0, 2'd1};
        vecs[9]  = '{5'h1E, 1'b1, 5'h01, 5'h00, 5'h00, 1'b0, 2'd1};
        vecs[10] = '{5'h1E, 1'b1, 5'h01, 5'h00, 5'h00, 1'b1, 2'd2};
        vecs[11] = '{5'h1F, 1'b1, 5'h01, 5'h00, 5'h00, 1'b1, 2'd2};
        vecs[12] = '{5'h1F, 1'b1, 5'h01, 5'h00, 5'h00, 1'b1, 2'd2};
        vecs[13] = '{5'h1F, 1'b1, 5'h01, 5'h00, 5'h00, 1'b1, 2'd2};
        vecs[14] = '{5'h1F, 1'b1, 5'h01, 5'h00, 5'h00, 1'b1, 2'd2};
        vecs[15] = '{5'h1F, 1'b1, 5'h01, 5'h00, 5'h00, 1'b1, 2'd2};
        vecs[16] = '{5'h1F, 1'b1, 5'h00, 5'h00, 5'h01, 1'b1, 2'd2};
        vecs[17] = '{5'h1F, 1'b1, 5'h00, 5'h00, 5'h00, 1'b1, 2'd2};

        reset_n    = 1'b0;
        keys_in    = 5'h1E;
        pll_locked = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset keys_out", 32'(keys_out), 32'(0));
        check("reset key_pressed", 32'(key_pressed), 32'(0));
        check("reset key_released", 32'(key_released), 32'(0));
        check("reset sys_reset_n", 32'(sys_reset_n), 32'(0));
        check("reset reset_state", 32'(reset_state), 32'(0));
        #1 reset_n = 1'b1;

        // Clean press/release and power-up sequencing.
        for (int r = 0; r < 18; r++) begin
            keys_in    = vecs[r].keys;
            pll_locked = vecs[r].pll;
            tick();
            check($sformatf("vec%0d keys_out", r + 1), 32'(keys_out), 32'(vecs[r].ko));
            check($sformatf("vec%0d key_pressed", r + 1), 32'(key_pressed), 32'(vecs[r].kp));
            check($sformatf("vec%0d key_released", r + 1), 32'(key_released), 32'(vecs[r].kr));
            check($sformatf("vec%0d sys_reset_n", r + 1), 32'(sys_reset_n), 32'(vecs[r].srn));
            check($sformatf("vec%0d reset_state", r + 1), 32'(reset_state), 32'(vecs[r].st));
        end

        // Bounce on key1 every 3 cycles: never accepted.
        for (int c = 0; c < 48; c++) begin
            keys_in[1] = (c < 40 && (c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            check("bounce keys_out1", 32'(keys_out[1]), 32'(0));
            check("bounce pressed", 32'(key_pressed), 32'(0));
            check("bounce released", 32'(key_released), 32'(0));
        end

        // Reset key pressed while in RUN, then released.
        for (int n = 1; n <= 22; n++) begin
            keys_in[2] = (n <= 7) ? 1'b0 : 1'b1;
            tick();
            if (n == 5) check("rkey ko2 before", 32'(keys_out[2]), 32'(0));
            if (n == 6) begin
                check("rkey ko2 set", 32'(keys_out[2]), 32'(1));
                check("rkey pressed2", 32'(key_pressed[2]), 32'(1));
                check("rkey still run", 32'(sys_reset_n), 32'(1));
            end
            if (n == 7) begin
                check("rkey srn low", 32'(sys_reset_n), 32'(0));
                check("rkey hold", 32'(reset_state), 32'(0));
            end
            if (n == 12) check("rkey ko2 held", 32'(keys_out[2]), 32'(1));
            if (n == 13) check("rkey ko2 clear", 32'(keys_out[2]), 32'(0));
            if (n == 21) begin
                check("rkey srn still low", 32'(sys_reset_n), 32'(0));
                check("rkey count", 32'(reset_state), 32'(1));
            end
            if (n == 22) begin
                check("rkey srn high", 32'(sys_reset_n), 32'(1));
                check("rkey run", 32'(reset_state), 32'(2));
            end
        end

        // PLL drop to HOLD, relock, then a 3-cycle glitch with the stretch counter at 5.
        for (int i = 1; i <= 26; i++) begin
            keys_in[4] = 1'b0;
            pll_locked = (i <= 5 || (i >= 12 && i <= 14)) ? 1'b0 : 1'b1;
            tick();
            if (i == 2) check("pll still run", 32'(reset_state), 32'(2));
            if (i == 3) begin
                check("pll drop hold", 32'(reset_state), 32'(0));
                check("pll drop srn", 32'(sys_reset_n), 32'(0));
            end
            if (i == 8) check("pll relock count", 32'(reset_state), 32'(1));
            if (i == 13) check("pll glitch count5", 32'(reset_state), 32'(1));
            if (i >= 14 && i <= 16) begin
                check("pll glitch hold", 32'(reset_state), 32'(0));
                check("pll glitch srn", 32'(sys_reset_n), 32'(0));
            end
            if (i == 17) check("pll restretch count", 32'(reset_state), 32'(1));
            if (i == 24) begin
                check("pll restretch not yet", 32'(reset_state), 32'(1));
                check("pll restretch srn low", 32'(sys_reset_n), 32'(0));
            end
            if (i == 25) begin
                check("pll restretch run", 32'(reset_state), 32'(2));
                check("pll restretch srn", 32'(sys_reset_n), 32'(1));
            end
        end

        // Async reset with key3 mid-debounce and the sequencer in RUN.
        keys_in[3] = 1'b0;
        repeat (5) tick();
        check("mid ko3 pending", 32'(keys_out[3]), 32'(0));
        check("mid ko4 held", 32'(keys_out[4]), 32'(1));
        check("mid run", 32'(reset_state), 32'(2));
        pulse_reset();
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n < 6) check("post-reset ko", 32'(keys_out), 32'(0));
            if (n == 3) check("post-reset count", 32'(reset_state), 32'(1));
            if (n == 6) begin
                check("post-reset ko full", 32'(keys_out), 32'(5'h18));
                check("post-reset pressed", 32'(key_pressed), 32'(5'h18));
            end
        end

        // Randomized traffic against the reference model.
        keys_in    = IDLE_RAW;
        pll_locked = 1'b1;
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 4) == 0) keys_in[k] = ~keys_in[k];
            if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
            tick();
            if ($urandom_range(0, 499) == 0) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
